// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction fetch unit.
//   XLEN             - instruction and word-address width (32)
//   RESET_PC_DEFAULT - default word address fetched first after reset
//   fetch_state_e    - fetch control state (IDLE / RUN / DRAIN)
//   next_pc()        - word-granular successor address, wraps at 2^32
package fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch unit's memory, redirect and decode-side
// signals.
//   master - fetch unit side (drives requests and the decode output)
//   slave  - environment side (memory, datapath redirect, decode)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; once valid is raised it stays high with a stable payload until
// that transfer, except that a redirect cancels a pending fetch request.
// imem_resp_valid has no ready: responses come back in request order and
// must be taken the cycle they arrive. redirect_valid is a one-cycle pulse.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH x WIDTH synchronous FIFO with a synchronous flush.
//   clk, rst_n  - clock, asynchronous active-low reset
//   flush       - empties the FIFO; wins over push and pop in the same cycle
//   push/push_data - write request; accepted when not full, or when full
//                    and a pop happens in the same cycle
//   pop         - removes the head entry when not empty
//   head_data   - head entry, combinational
//   empty, full, count - occupancy status
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

    assign do_pop  = pop && !empty && !flush;
    // A full FIFO can still take a push when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];

    // A push that finds the FIFO full with no pop would lose data.
    overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - fetch_unit_if.master: imem request/response, redirect,
//                decode output
//   dbg_state  - current control state
// Requests are issued on a credit basis: outstanding requests plus buffered
// instructions never exceed DEPTH, so every response has a buffer slot. Each
// accepted address goes into a tag queue and is paired with its response.
// A redirect flushes the buffer, retargets fetch_pc and arms a discard
// counter that swallows responses to requests issued before the redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus,
    output fetch_state_e dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic              redirect, accept, resp_ok, credit_ok, req_valid;
    logic              buf_push, buf_pop, buf_empty, buf_full;
    logic [CW-1:0]     buf_count;
    logic [2*XLEN-1:0] buf_head;
    logic [XLEN-1:0]   tag_head;
    logic              tag_empty, tag_full;
    logic [CW-1:0]     tag_count;

    assign redirect = bus.redirect_valid;
    assign accept   = req_valid && bus.imem_req_ready;
    // A response with no tag in flight is stale (e.g. issued before a reset).
    assign resp_ok  = bus.imem_resp_valid && !tag_empty;

    assign credit_ok = ({1'b0, outstanding_q} + {1'b0, buf_count}) < CREDIT_LIMIT;
    assign req_valid = (state_q != ST_IDLE) && credit_ok && !redirect;

    assign buf_push = resp_ok && (discard_q == '0) && !redirect;
    assign buf_pop  = !buf_empty && bus.out_ready;

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(2 * XLEN)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (buf_push),
        .push_data ({tag_head, bus.imem_resp_data}),
        .pop       (buf_pop),
        .head_data (buf_head),
        .empty     (buf_empty),
        .full      (buf_full),
        .count     (buf_count)
    );

    // Tags are never flushed: discarded responses still retire their tag.
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_tag (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .push      (accept),
        .push_data (fetch_pc_q),
        .pop       (resp_ok),
        .head_data (tag_head),
        .empty     (tag_empty),
        .full      (tag_full),
        .count     (tag_count)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        case ({accept, resp_ok})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect) begin
            fetch_pc_d = bus.redirect_pc;
            // Everything still in flight is stale; a response arriving right
            // now is already dropped, so it is not counted again.
            discard_d  = outstanding_q - CW'(resp_ok);
        end else begin
            if (accept) begin
                fetch_pc_d = next_pc(fetch_pc_q);
            end
            if (resp_ok && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
        end

        case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN,
            ST_DRAIN: state_d = (discard_d != '0) ? ST_DRAIN : ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        bus.imem_req_valid = req_valid;
        bus.imem_req_addr  = fetch_pc_q;
        bus.out_valid      = !buf_empty;
        bus.out_pc         = buf_empty ? '0 : buf_head[2*XLEN-1:XLEN];
        bus.out_instr      = buf_empty ? '0 : buf_head[XLEN-1:0];
        dbg_state          = state_q;
    end

    tag_track_a: assert property (@(posedge clk) disable iff (!rst_n)
        (tag_count == outstanding_q) && !(accept && tag_full));
    full_no_inflight_a: assert property (@(posedge clk) disable iff (!rst_n)
        buf_full |-> (outstanding_q == '0));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int DEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'd0;

    logic         clk = 1'b0;
    logic         rst_n;
    fetch_state_e dbg_state;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- bench state ----------------
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cycle    = 0;
    int unsigned lat      = 1;

    logic [31:0] mem_addr_q[$];
    int unsigned mem_due_q[$];
    logic [31:0] acc_q[$];
    logic [31:0] obs_pc_q[$];
    logic [31:0] obs_instr_q[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; samples the cycle at the falling edge
    // and returns just after the next rising edge with new inputs applied.
    task automatic tick();
        logic [31:0] a;
        @(negedge clk);
        if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
            acc_q.push_back(bus.imem_req_addr);
            mem_addr_q.push_back(bus.imem_req_addr);
            mem_due_q.push_back(cycle + lat);
        end
        if (rst_n && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
            obs_pc_q.push_back(bus.out_pc);
            obs_instr_q.push_back(bus.out_instr);
        end
        @(posedge clk);
        #1;
        cycle++;
        bus.redirect_valid = 1'b0;
        if (mem_addr_q.size() > 0 && mem_due_q[0] <= cycle) begin
            a = mem_addr_q.pop_front();
            void'(mem_due_q.pop_front());
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mem_word(a);
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = '0;
        end
    endtask

    task automatic clear_obs();
        obs_pc_q.delete();
        obs_instr_q.delete();
        acc_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.out_ready       = 1'b1;
        mem_addr_q.delete();
        mem_due_q.delete();
        clear_obs();
        #1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        clear_obs();
        #1;
        check("redir_req_valid_T", 32'(bus.imem_req_valid), 32'd0);
        tick();
    endtask

    task automatic wait_inflight(input string tag, input int n);
        int k;
        k = 0;
        while (mem_addr_q.size() < n && k < 50) begin
            tick();
            k++;
        end
        check(tag, 32'(mem_addr_q.size()), 32'(n));
    endtask

    // ---------------- scoreboard ----------------
    task automatic expect_drain(input string tag, input logic [31:0] start, input int n);
        logic [31:0] e;
        int avail;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(i));
        avail = (obs_pc_q.size() >= n) ? n : obs_pc_q.size();
        check({tag, "_count"}, 32'(avail), 32'(n));
        for (int i = 0; i < avail; i++) begin
            e = exp_q.pop_front();
            check({tag, "_pc"}, obs_pc_q.pop_front(), e);
            check({tag, "_instr"}, obs_instr_q.pop_front(), mem_word(e));
        end
    endtask

    // ---------------- tests ----------------
    logic [31:0] held;
    int          n_acc;

    initial begin
        rst_n = 1'b1;
        #3;

        // Reset values and sequential fetch.
        do_reset();
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_req_addr", bus.imem_req_addr, RESET_PC);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_out_pc", bus.out_pc, 32'd0);
        check("rst_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        check("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("first_req_addr", bus.imem_req_addr, RESET_PC);
        check("first_state_run", 32'(dbg_state), 32'(ST_RUN));
        repeat (20) tick();
        expect_drain("seq", RESET_PC, 4);

        // Back-pressure from decode: exactly DEPTH requests, then drain.
        do_reset();
        bus.out_ready = 1'b0;
        repeat (10) tick();
        check("bp_requests", 32'(acc_q.size()), 32'(DEPTH));
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("bp_head_pc", bus.out_pc, RESET_PC);
        bus.out_ready = 1'b1;
        repeat (12) tick();
        expect_drain("bp", RESET_PC, 4);

        // Redirect with two requests in flight.
        do_reset();
        lat = 3;
        wait_inflight("redir_inflight", 2);
        redirect_to(32'h40);
        check("redir_out_valid_T1", 32'(bus.out_valid), 32'd0);
        check("redir_req_addr_T1", bus.imem_req_addr, 32'h40);
        check("redir_state_drain", 32'(dbg_state), 32'(ST_DRAIN));
        repeat (20) tick();
        check("redir_state_run", 32'(dbg_state), 32'(ST_RUN));
        expect_drain("redir", 32'h40, 3);

        // Memory stall: address held, fetch_pc not advanced.
        do_reset();
        lat = 1;
        repeat (6) tick();
        bus.imem_req_ready = 1'b0;
        tick();
        tick();
        held = acc_q[acc_q.size() - 1] + 32'd1;
        check("stall_addr0", bus.imem_req_addr, held);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_addr", bus.imem_req_addr, held);
            check("stall_valid", 32'(bus.imem_req_valid), 32'd1);
        end
        n_acc = acc_q.size();
        bus.imem_req_ready = 1'b1;
        tick();
        check("resume_cnt", 32'(acc_q.size()), 32'(n_acc + 1));
        if (acc_q.size() > n_acc) check("resume_addr", acc_q[n_acc], held);
        repeat (12) tick();
        expect_drain("stall", RESET_PC, 6);

        // Redirect to the top of the address space: wrap to zero.
        do_reset();
        repeat (6) tick();
        redirect_to(32'hFFFF_FFFF);
        repeat (15) tick();
        expect_drain("wrap", 32'hFFFF_FFFF, 3);

        // Reset mid-transaction: late responses ignored, restart at RESET_PC.
        do_reset();
        lat = 3;
        wait_inflight("rst_inflight", 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_req_addr", bus.imem_req_addr, RESET_PC);
        check("mid_rst_out_pc", bus.out_pc, 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        tick();
        rst_n = 1'b1;
        clear_obs();
        repeat (20) tick();
        check("restart_first_addr", (acc_q.size() > 0) ? acc_q[0] : 32'hFFFF_FFFF, RESET_PC);
        expect_drain("restart", RESET_PC, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'd0, word address fetched first after reset.
REQ-002 Parameter DEPTH, default 2, instruction buffer entries (power of two, >=2); outstanding-request limit equals DEPTH.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request.
REQ-007 imem_req_addr  output  32  word address of request.
REQ-008 imem_resp_valid  input  1  response data valid; responses return in request order, >=1 cycle after acceptance, no back-pressure.
REQ-009 imem_resp_data  input  32  instruction word.
REQ-010 redirect_valid  input  1  one-cycle branch/jump taken pulse from the datapath.
REQ-011 redirect_pc  input  32  new word address.
REQ-012 out_valid  output  1  instruction available to decode.
REQ-013 out_ready  input  1  decode consumes instruction.
REQ-014 out_instr  output  32  instruction at buffer head.
REQ-015 out_pc  output  32  word address of out_instr.

Function
REQ-016 Addressing SHALL be word-granular: next fetch address = current + 1, 32-bit wrap 32'hFFFFFFFF -> 0.
REQ-017 Request accepted when imem_req_valid & imem_req_ready; fetch_pc increments on each acceptance.
REQ-018 imem_req_valid SHALL be high iff outstanding + buffer occupancy < DEPTH and no redirect is asserted this cycle; imem_req_addr = fetch_pc, stable while valid and not ready.
REQ-019 Each accepted request SHALL record its address in a DEPTH-entry in-flight tag queue; each good response pairs with the oldest tag and writes {pc, instr} to the buffer.
REQ-020 Buffer is FIFO; out_valid = not empty; out_instr/out_pc combinationally from head; pop on out_valid & out_ready.
REQ-021 Simultaneous pop and push on a full buffer SHALL be legal; occupancy unchanged.
REQ-022 Credit rule guarantees every response finds space; overflow is impossible and SHALL be flagged by assertion.
REQ-023 Redirect (cycle T): buffer cleared, fetch_pc <- redirect_pc, out_valid low in T+1, imem_req_valid low in T, new request at redirect_pc visible in T+1.
REQ-024 Responses to requests accepted before/at T SHALL be discarded: at T the discard counter loads the outstanding count (minus any response arriving in T); each later response decrements it, is not written.
REQ-025 New requests after redirect SHALL be issued while discard count > 0, subject to REQ-018 counting discards as outstanding.
REQ-026 Redirect wins over same-cycle pop, push and request acceptance; a second redirect while discarding SHALL re-apply REQ-024.
REQ-027 State: IDLE (post-reset, one cycle), RUN, DRAIN (discard count > 0); IDLE->RUN always; RUN->DRAIN on redirect with outstanding >0; DRAIN->RUN when count reaches 0 with no redirect.
REQ-028 Outstanding counter width = clog2(DEPTH)+1; increments on acceptance, decrements on any response, both same cycle = unchanged.

Reset
REQ-029 On rst_n low, asynchronously: fetch_pc = RESET_PC, buffer/tag queue empty, counters 0, state IDLE.
REQ-030 Reset outputs: imem_req_valid 0, out_valid 0, imem_req_addr RESET_PC, out_instr 0, out_pc 0.
REQ-031 Reset asserted mid-transaction SHALL abandon all in-flight requests; responses arriving during reset ignored.
REQ-032 First request SHALL be driven in the second rising edge after rst_n deasserts (IDLE cycle).

Structure
REQ-033 Shared package holds instruction/address width constant (32), fetch state enum, and RESET_PC default.
REQ-034 One sub-module: fetch_fifo (parameterised DEPTH x 64-bit sync FIFO, flush input), instantiated for the buffer; tag queue may reuse it at 32-bit width.

Verification
REQ-035 Reset release, imem ready always, 1-cycle latency, out_ready=1 -> out_pc 0,1,2,3 consecutive, instr matches memory[pc].
REQ-036 out_ready=0 for 10 cycles -> exactly DEPTH requests issued, buffer full, no further requests; release -> in-order drain, no loss.
REQ-037 Redirect to 32'h40 with 2 outstanding -> both responses dropped, next out_pc 32'h40, no stale instruction visible.
REQ-038 imem_req_ready low 5 cycles -> imem_req_addr held constant, fetch_pc not advanced.
REQ-039 Redirect to 32'hFFFFFFFF -> out_pc sequence FFFFFFFF, 0, 1.
REQ-040 rst_n pulsed low with 2 requests in flight -> outputs at reset values, late responses ignored, restart from RESET_PC.
